// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up/initialisation sequencer: power-up wait, PRECHARGE-ALL,
// N x AUTO-REFRESH, LOAD-MODE with tRP/tRFC/tMRD gaps, settle, then ready.
// Ports: clk, rst (async high), start (level run/abort),
//   cmd_valid/cmd_op/cmd_ack (command handshake), sdram_init_n,
//   sdram_ready, phase (state code), init_err (ack timeout).
// Option: define SDRAM_INIT_WATCHDOG_EN to enable the ack watchdog.
module sdram_init_sequencer #(
  parameter real CLK           = 111857000.0,
  parameter real POWERUP_S     = 0.201,
  parameter int  REFRESH_COUNT = 8,
  parameter int  TRP_CYCLES    = 3,
  parameter int  TRFC_CYCLES   = 8,
  parameter int  TMRD_CYCLES   = 2,
  parameter int  SETTLE_CYCLES = 63,
  parameter int  ACK_TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  input  logic       cmd_ack,
  output logic       sdram_init_n,
  output logic       sdram_ready,
  output logic [3:0] phase,
  output logic       init_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ceil(POWERUP_S*CLK), at least 1
  localparam real PW_R  = POWERUP_S * CLK;
  localparam int  PW_T  = $rtoi(PW_R);
  localparam int  PW_C  = ($itor(PW_T) < PW_R) ? PW_T + 1 : PW_T;
  localparam int  CYC_PW = (PW_C < 1) ? 1 : PW_C;

  localparam int MAXC = max2(max2(max2(CYC_PW, TRP_CYCLES),
                                  max2(TRFC_CYCLES, TMRD_CYCLES)),
                             max2(SETTLE_CYCLES, ACK_TIMEOUT));
  localparam int CW = $clog2(MAXC) + 1;

  typedef logic [CW-1:0] cnt_t;

  // Counter reload values: a state lasts load+1 cycles; zero waits
  // still take one cycle.
  localparam cnt_t L_PW  = cnt_t'(CYC_PW - 1);
  localparam cnt_t L_RP  = cnt_t'((TRP_CYCLES    > 0) ? TRP_CYCLES    - 1 : 0);
  localparam cnt_t L_RFC = cnt_t'((TRFC_CYCLES   > 0) ? TRFC_CYCLES   - 1 : 0);
  localparam cnt_t L_MRD = cnt_t'((TMRD_CYCLES   > 0) ? TMRD_CYCLES   - 1 : 0);
  localparam cnt_t L_SET = cnt_t'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef SDRAM_INIT_WATCHDOG_EN
  localparam cnt_t L_ACK = cnt_t'((ACK_TIMEOUT   > 0) ? ACK_TIMEOUT   - 1 : 0);
`else
  localparam cnt_t L_ACK = '0;
`endif

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_PRE = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;
  localparam logic [1:0] OP_MRS = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PWRUP = 4'd1,
    S_PRE   = 4'd2,
    S_WRP   = 4'd3,
    S_REF   = 4'd4,
    S_WRFC  = 4'd5,
    S_MRS   = 4'd6,
    S_WMRD  = 4'd7,
    S_SET   = 4'd8,
    S_RDY   = 4'd9,
    S_ERR   = 4'd15
  } state_e;

  state_e     state_q;
  cnt_t       cnt_q;
  logic [7:0] ref_q;
  logic       valid_q;
  logic [1:0] op_q;
  logic       init_n_q;
  logic       ready_q;
`ifdef SDRAM_INIT_WATCHDOG_EN
  logic       err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      valid_q  <= 1'b0;
      op_q     <= OP_NOP;
      init_n_q <= 1'b1;
      ready_q  <= 1'b0;
`ifdef SDRAM_INIT_WATCHDOG_EN
      err_q    <= 1'b0;
`endif
    end else if (!start) begin
      // Abort from anywhere; also the IDLE hold condition.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      valid_q  <= 1'b0;
      op_q     <= OP_NOP;
      init_n_q <= 1'b1;
      ready_q  <= 1'b0;
`ifdef SDRAM_INIT_WATCHDOG_EN
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q  <= S_PWRUP;
          init_n_q <= 1'b0;
          cnt_q    <= L_PW;
        end
        S_PWRUP: begin
          if (cnt_q == '0) begin
            state_q  <= S_PRE;
            init_n_q <= 1'b1;
            valid_q  <= 1'b1;
            op_q     <= OP_PRE;
            cnt_q    <= L_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // cmd_valid is always high in these states, so ack alone
        // completes the transfer.
        S_PRE, S_REF, S_MRS: begin
          if (cmd_ack) begin
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            state_q <= (state_q == S_PRE) ? S_WRP :
                       (state_q == S_REF) ? S_WRFC : S_WMRD;
            cnt_q   <= (state_q == S_PRE) ? L_RP :
                       (state_q == S_REF) ? L_RFC : L_MRD;
          end
`ifdef SDRAM_INIT_WATCHDOG_EN
          else if (cnt_q == '0) begin
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`endif
        end
        S_WRP: begin
          if (cnt_q == '0) begin
            state_q <= S_REF;
            valid_q <= 1'b1;
            op_q    <= OP_REF;
            ref_q   <= 8'd1;
            cnt_q   <= L_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WRFC: begin
          if (cnt_q == '0) begin
            valid_q <= 1'b1;
            cnt_q   <= L_ACK;
            if (ref_q < 8'(REFRESH_COUNT)) begin
              state_q <= S_REF;
              op_q    <= OP_REF;
              ref_q   <= ref_q + 8'd1;
            end else begin
              state_q <= S_MRS;
              op_q    <= OP_MRS;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WMRD: begin
          if (cnt_q == '0) begin
            state_q <= S_SET;
            cnt_q   <= L_SET;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SET: begin
          if (cnt_q == '0) begin
            state_q <= S_RDY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RDY, S_ERR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid    = valid_q;
  assign cmd_op       = op_q;
  assign sdram_init_n = init_n_q;
  assign sdram_ready  = ready_q;
  assign phase        = state_q;
`ifdef SDRAM_INIT_WATCHDOG_EN
  assign init_err     = err_q;
`else
  assign init_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Directed bench for sdram_init_sequencer: full sequence, delayed ack,
// abort/restart, async reset, watchdog (when built in), zero tRP.
module tb_sdram_init_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       valid, init_n, ready, err;
  logic [1:0] op;
  logic [3:0] phase;

  logic       start0 = 1'b0;
  logic       ack0 = 1'b1;
  logic       valid0, init_n0, ready0, err0;
  logic [1:0] op0;
  logic [3:0] phase0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_init_sequencer #(
    .CLK(1000.0), .POWERUP_S(0.01), .REFRESH_COUNT(2),
    .TRP_CYCLES(3), .TRFC_CYCLES(4), .TMRD_CYCLES(2),
    .SETTLE_CYCLES(5), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_valid(valid), .cmd_op(op), .cmd_ack(ack),
    .sdram_init_n(init_n), .sdram_ready(ready),
    .phase(phase), .init_err(err)
  );

  sdram_init_sequencer #(
    .CLK(1000.0), .POWERUP_S(0.01), .REFRESH_COUNT(1),
    .TRP_CYCLES(0), .TRFC_CYCLES(4), .TMRD_CYCLES(2),
    .SETTLE_CYCLES(5), .ACK_TIMEOUT(16)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .cmd_valid(valid0), .cmd_op(op0), .cmd_ack(ack0),
    .sdram_init_n(init_n0), .sdram_ready(ready0),
    .phase(phase0), .init_err(err0)
  );

  // Expected phase after edge k (index k-1), start raised before edge 1.
  int e1[33] = '{1,1,1,1,1,1,1,1,1,1,
                 2,3,3,3,4,5,5,5,5,4,
                 5,5,5,5,6,7,7,8,8,8,
                 8,8,9};
  int e0[26] = '{1,1,1,1,1,1,1,1,1,1,
                 2,3,4,5,5,5,5,6,7,7,
                 8,8,8,8,8,9};

  // {valid, op, init_n, ready, err} expected in a given phase
  function automatic logic [5:0] exp_bus(input int ph);
    logic       v;
    logic [1:0] o;
    v = (ph == 2) || (ph == 4) || (ph == 6);
    o = (ph == 2) ? 2'd1 : (ph == 4) ? 2'd2 : (ph == 6) ? 2'd3 : 2'd0;
    return {v, o, ph != 1, ph == 9, ph == 15};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Run a full sequence on dut; ack withheld for `stall` cycles on REF #1.
  task automatic run_seq(input int stall);
    int e;
    ack = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 33 + stall; k++) begin
      @(negedge clk);
      if (k <= 15) e = e1[k-1];
      else if (k <= 15 + stall) e = 4;
      else e = e1[k-1-stall];
      chk($sformatf("phase_k%0d_s%0d", k, stall), 32'(phase), 32'(e));
      chk($sformatf("bus_k%0d_s%0d", k, stall),
          32'({valid, op, init_n, ready, err}), 32'(exp_bus(e)));
      if (stall > 0 && k == 14) ack = 1'b0;
      if (stall > 0 && k == 15 + stall) ack = 1'b1;
    end
  endtask

  initial begin
    int nref;
    tick(2);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_bus", 32'({valid, op, init_n, ready, err}), 32'(exp_bus(0)));
    chk("rst_phase0", 32'(phase0), 32'd0);
    rst = 1'b0;
    tick(3);
    chk("idle_hold", 32'(phase), 32'd0);

    run_seq(0);
    tick(4);
    chk("ready_hold_ph", 32'(phase), 32'd9);
    chk("ready_hold_bus",
        32'({valid, op, init_n, ready, err}), 32'(exp_bus(9)));
    start = 1'b0;
    tick(1);
    chk("abort_rdy_ph", 32'(phase), 32'd0);
    chk("abort_rdy_bus",
        32'({valid, op, init_n, ready, err}), 32'(exp_bus(0)));

    run_seq(6);
    start = 1'b0;
    tick(1);
    chk("abort2_ph", 32'(phase), 32'd0);

    ack = 1'b1;
    start = 1'b1;
    tick(17);
    chk("mid_rfc_ph", 32'(phase), 32'd5);
    start = 1'b0;
    tick(1);
    chk("abort_rfc_ph", 32'(phase), 32'd0);
    chk("abort_rfc_bus",
        32'({valid, op, init_n, ready, err}), 32'(exp_bus(0)));
    tick(2);
    chk("abort_rfc_idle", 32'(phase), 32'd0);
    run_seq(0);
    start = 1'b0;
    tick(1);

    ack = 1'b0;
    start = 1'b1;
    tick(11);
    chk("pre_pend_ph", 32'(phase), 32'd2);
    chk("pre_pend_v", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ph", 32'(phase), 32'd0);
    chk("arst_bus", 32'({valid, op, init_n, ready, err}), 32'(exp_bus(0)));
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ph", 32'(phase), 32'd1);
    chk("post_rst_initn", 32'(init_n), 32'd0);
    start = 1'b0;
    tick(1);

    ack = 1'b0;
    start = 1'b1;
    tick(26);
    chk("wd_last_ph", 32'(phase), 32'd2);
    chk("wd_last_v", 32'(valid), 32'd1);
    tick(1);
`ifdef SDRAM_INIT_WATCHDOG_EN
    chk("wd_err_ph", 32'(phase), 32'd15);
    chk("wd_err_bus",
        32'({valid, op, init_n, ready, err}), 32'(exp_bus(15)));
    tick(3);
    chk("wd_hold_ph", 32'(phase), 32'd15);
`else
    chk("nowd_ph", 32'(phase), 32'd2);
    chk("nowd_bus", 32'({valid, op, init_n, ready, err}), 32'(exp_bus(2)));
    tick(20);
    chk("nowd_hold_ph", 32'(phase), 32'd2);
`endif
    start = 1'b0;
    tick(1);
    chk("clr_ph", 32'(phase), 32'd0);
    chk("clr_err", 32'(err), 32'd0);

    nref = 0;
    start0 = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      chk($sformatf("z_phase_k%0d", k), 32'(phase0), 32'(e0[k-1]));
      chk($sformatf("z_bus_k%0d", k),
          32'({valid0, op0, init_n0, ready0, err0}), 32'(exp_bus(e0[k-1])));
      if (valid0 && op0 == 2'd2) nref++;
    end
    chk("z_ref_count", 32'(nref), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_init_sequencer.md
Name: sdram_init_sequencer

Overview:
Parametrised SDRAM power-up and initialisation sequencer that succeeds the fixed 200 ms startup-delay unit. It times the power-up wait, then issues PRECHARGE-ALL, a configurable number of AUTO-REFRESH commands and LOAD-MODE to the SDRAM controller over a valid/ack handshake, observing tRP/tRFC/tMRD gaps. After a settle window it asserts ready. It sits between board-level start logic and the SDRAM controller command mux.

Parameters:
CLK, 111857000.0, clock frequency in Hz (real)
POWERUP_S, 0.201, power-up wait in seconds; CYCLES_PWRUP = ceil(POWERUP_S*CLK), minimum 1
REFRESH_COUNT, 8, AUTO-REFRESH commands issued (1..255)
TRP_CYCLES, 3, idle cycles after PRECHARGE ack
TRFC_CYCLES, 8, idle cycles after each AUTO-REFRESH ack
TMRD_CYCLES, 2, idle cycles after LOAD-MODE ack
SETTLE_CYCLES, 63, cycles from end of tMRD to ready
ACK_TIMEOUT, 1023, max cycles cmd_valid may wait for ack (SDRAM_INIT_WATCHDOG_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; high runs/holds sequence, low aborts and returns to IDLE
cmd_valid  out  1  command request to controller
cmd_op  out  2  00 NOP, 01 PRECHARGE_ALL, 10 AUTO_REFRESH, 11 LOAD_MODE
cmd_ack  in  1  controller accepts command when high with cmd_valid high
sdram_init_n  out  1  low during power-up wait only
sdram_ready  out  1  high once sequence complete
phase  out  4  current state encoding (debug)
init_err  out  1  ack timeout flag (tied 0 without watchdog)

Behaviour:
- Reset (async, immediate): state IDLE; cmd_valid=0, cmd_op=00, sdram_init_n=1, sdram_ready=0, phase=0, init_err=0, all counters 0.
- All outputs registered. One down-counter sized $clog2(max of all cycle parameters)+1 bits, shared; refresh counter 8 bits.
- States / phase codes: IDLE=0, PWRUP=1, PRE=2, WAIT_RP=3, REF=4, WAIT_RFC=5, MRS=6, WAIT_MRD=7, SETTLE=8, READY=9, ERROR=15.
- IDLE: start sampled high at edge E0 -> PWRUP; sdram_init_n=0 from E0.
- PWRUP: sdram_init_n=0 for exactly CYCLES_PWRUP cycles; then sdram_init_n=1, -> PRE with cmd_valid=1, cmd_op=01 on same edge.
- Command states (PRE, REF, MRS): cmd_valid and cmd_op held stable until edge where cmd_ack=1; on that edge cmd_valid=0, cmd_op=00, enter matching WAIT state. Ack in same cycle valid first rises counts (1-cycle transfer). cmd_ack while cmd_valid=0 ignored.
- WAIT_RP: TRP_CYCLES cycles -> REF (cmd_valid=1, op=10), refresh count=1.
- WAIT_RFC: TRFC_CYCLES cycles; if refreshes issued < REFRESH_COUNT -> REF again, else -> MRS (op=11).
- WAIT_MRD: TMRD_CYCLES cycles -> SETTLE. SETTLE: SETTLE_CYCLES cycles -> READY, sdram_ready=1 on that edge.
- A zero-valued wait parameter means the WAIT state lasts exactly 1 cycle (no zero-length skip).
- READY: holds while start=1; further cmd_ack ignored.
- start low in any state (incl. mid-handshake, mid-wait): next edge -> IDLE, cmd_valid=0, cmd_op=00, sdram_ready=0, sdram_init_n=1, counters cleared, init_err cleared. Re-raising start restarts full sequence from PWRUP.
- start low in IDLE: stay IDLE.

Optional Feature:
SDRAM_INIT_WATCHDOG_EN: defined -> a wait counter runs while cmd_valid=1 and ack not yet seen; after ACK_TIMEOUT cycles without ack, next edge: cmd_valid=0, init_err=1, state ERROR; ERROR holds until start low or rst. Undefined -> no watchdog logic, sequencer waits for ack indefinitely, init_err tied 0, ERROR unreachable.

Test Plan:
- CLK=1000.0, POWERUP_S=0.01, REFRESH_COUNT=2, TRP=3, TRFC=4, TMRD=2, SETTLE=5, cmd_ack tied 1, start raised -> sdram_init_n low 10 cycles; op sequence 01,10,10,11 each valid 1 cycle, gaps 3,4,4,2; sdram_ready high 5 cycles after tMRD; phase ends 9.
- Same params, ack delayed 6 cycles on REF #1 -> cmd_valid/op=10 stable 7 cycles, sequence otherwise unchanged, total latency +6.
- start dropped 2 cycles into WAIT_RFC, raised 3 cycles later -> IDLE next edge with all outputs at reset values; sdram_init_n low again for 10 cycles, full sequence repeats.
- rst pulsed asynchronously mid-PRE handshake -> cmd_valid, sdram_ready, phase cleared without clock edge; after release with start=1 -> PWRUP.
- Watchdog build, ACK_TIMEOUT=16, cmd_ack tied 0 -> cmd_valid high 16 cycles then low, init_err=1, phase=15; start low -> init_err=0, phase=0.
- TRP_CYCLES=0, REFRESH_COUNT=1 -> WAIT_RP lasts 1 cycle; exactly one op 10 issued before 11.
